// File: rtl/key_event_conditioner.sv
// key_event_conditioner: synchronise and debounce a push-button, classify short/long presses
// and publish sticky event flags plus a wrapping press counter.
module key_event_conditioner #(
    parameter int DEBOUNCE_CYCLES = 270000,
    parameter int LONG_CYCLES     = 27000000,
    parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
    input  logic       sys_clk_i,
    input  logic       reset_i,
    input  logic       key_i,
    input  logic       ack_i,
    output logic       key_level_o,
    output logic       press_flag_o,
    output logic       long_flag_o,
    output logic [7:0] press_count_o
);
    localparam int   DW      = $clog2(DEBOUNCE_CYCLES);
    localparam int   HW      = $clog2(LONG_CYCLES);
    localparam logic REL_PIN = KEY_ACTIVE_LOW;

    typedef enum logic [1:0] {REL, PRS, LNG} state_t;

    state_t        state, state_n;
    logic          s1, s2, k_s, ack_d, ack_rise;
    logic          deb_done, rise, fall, set_press, set_long;
    logic [DW-1:0] deb_cnt;
    logic [HW-1:0] hold_cnt, hold_n;

    assign k_s      = s2 ^ KEY_ACTIVE_LOW;
    assign deb_done = (k_s != key_level_o) && (deb_cnt == DW'(DEBOUNCE_CYCLES - 1));
    assign rise     = deb_done & k_s;
    assign fall     = deb_done & ~k_s;
    assign ack_rise = ack_i & ~ack_d;

    always_ff @(posedge sys_clk_i) begin
        if (reset_i)
            state <= REL;
        else
            state <= state_n;
    end

    always_comb begin
        state_n   = state;
        hold_n    = hold_cnt;
        set_press = 1'b0;
        set_long  = 1'b0;
        case (state)
            REL: begin
                set_press = rise;
                state_n   = rise ? PRS : REL;
                hold_n    = '0;
            end
            PRS: begin
                set_long = hold_cnt == HW'(LONG_CYCLES - 1);
                state_n  = fall ? REL : set_long ? LNG : PRS;
                hold_n   = (fall | set_long) ? '0 : hold_cnt + HW'(1);
            end
            LNG: begin
                state_n = fall ? REL : LNG;
                hold_n  = '0;
            end
            default: begin
                state_n = REL;
                hold_n  = '0;
            end
        endcase
    end

    // A set on the same edge as an ack-clear wins.
    always_ff @(posedge sys_clk_i) begin
        if (reset_i) begin
            s1            <= REL_PIN;
            s2            <= REL_PIN;
            ack_d         <= 1'b0;
            key_level_o   <= 1'b0;
            deb_cnt       <= '0;
            hold_cnt      <= '0;
            press_flag_o  <= 1'b0;
            long_flag_o   <= 1'b0;
            press_count_o <= 8'd0;
        end else begin
            s1            <= key_i;
            s2            <= s1;
            ack_d         <= ack_i;
            key_level_o   <= deb_done ? k_s : key_level_o;
            deb_cnt       <= (k_s == key_level_o || deb_done) ? '0 : deb_cnt + DW'(1);
            hold_cnt      <= hold_n;
            press_flag_o  <= set_press | (press_flag_o & ~ack_rise);
            long_flag_o   <= set_long | (long_flag_o & ~ack_rise);
            press_count_o <= press_count_o + {7'd0, set_press};
        end
    end
endmodule

// File: tb/tb_key_event_conditioner.sv
// tb_key_event_conditioner: directed and randomized checks against a window-based behavioural model.
module tb_key_event_conditioner;
    localparam int D = 4;
    localparam int L = 16;

    logic       clk = 1'b0;
    logic       reset_i = 1'b1;
    logic       key_i = 1'b1;
    logic       ack_i = 1'b0;
    logic       key_level_o, press_flag_o, long_flag_o;
    logic [7:0] press_count_o;

    int n_cmp = 0;
    int n_err = 0;

    bit       pq[$];
    bit       sq[$];
    bit       m_lvl, m_pf, m_lf, m_ack_prev;
    int       m_held;
    bit [7:0] m_cnt;

    always #5 clk = ~clk;

    key_event_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .LONG_CYCLES(L),
        .KEY_ACTIVE_LOW(1'b1)
    ) dut (
        .sys_clk_i(clk),
        .reset_i(reset_i),
        .key_i(key_i),
        .ack_i(ack_i),
        .key_level_o(key_level_o),
        .press_flag_o(press_flag_o),
        .long_flag_o(long_flag_o),
        .press_count_o(press_count_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: the debounced level flips once the last D synchronised samples all disagree with it;
    // the synchronised sample is the pressed state the pin showed two edges earlier.
    task automatic model_reset();
        pq = '{};
        sq = '{};
        repeat (2) pq.push_back(1'b0);
        repeat (D) sq.push_back(1'b0);
        m_lvl = 0; m_pf = 0; m_lf = 0; m_ack_prev = 0; m_held = 0; m_cnt = 0;
    endtask

    task automatic model_edge(input bit pr, input bit a, input bit r);
        bit s, old, flip;
        if (r) begin
            model_reset();
            return;
        end
        s = pq.pop_front();
        pq.push_back(pr);
        void'(sq.pop_front());
        sq.push_back(s);
        flip = 1;
        foreach (sq[i]) if (sq[i] == m_lvl) flip = 0;
        old = m_lvl;
        if (a && !m_ack_prev) begin
            m_pf = 0;
            m_lf = 0;
        end
        m_ack_prev = a;
        if (old) begin
            m_held++;
            if (m_held == L) m_lf = 1;
        end
        if (flip) begin
            m_lvl = !m_lvl;
            if (!old) begin
                m_pf = 1;
                m_cnt++;
                m_held = 0;
            end
        end
    endtask

    task automatic step(input bit pr, input bit a = 0, input bit r = 0);
        key_i = ~pr;
        ack_i = a;
        reset_i = r;
        @(posedge clk);
        model_edge(pr, a, r);
        @(negedge clk);
        check("lvl", key_level_o, m_lvl);
        check("press_flag", press_flag_o, m_pf);
        check("long_flag", long_flag_o, m_lf);
        check("count", press_count_o, m_cnt);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        // reset while the button is held
        repeat (3) begin
            step(1, 0, 1);
            check("rst_lvl", key_level_o, 0);
            check("rst_pf", press_flag_o, 0);
            check("rst_lf", long_flag_o, 0);
            check("rst_cnt", press_count_o, 0);
        end
        for (int i = 1; i <= 6; i++) begin
            step(1);
            if (i == 5) check("rst_rise_early", key_level_o, 0);
            if (i == 6) begin
                check("rst_rise", key_level_o, 1);
                check("rst_rise_cnt", press_count_o, 1);
            end
        end
        for (int i = 1; i <= 10; i++) begin
            step(0);
            if (i == 5) check("rst_fall_early", key_level_o, 1);
            if (i == 6) check("rst_fall", key_level_o, 0);
        end
        // ack held for 5 cycles clears exactly once
        for (int i = 1; i <= 5; i++) begin
            step(0, 1);
            check("ack_clear", press_flag_o, 0);
        end
        repeat (3) step(0);
        // clean short press
        for (int i = 1; i <= 10; i++) begin
            step(1);
            if (i == 5) check("short_pf_early", press_flag_o, 0);
            if (i == 6) begin
                check("short_lvl", key_level_o, 1);
                check("short_pf", press_flag_o, 1);
                check("short_cnt", press_count_o, 2);
            end
        end
        for (int i = 1; i <= 10; i++) begin
            step(0);
            if (i == 6) check("short_fall", key_level_o, 0);
        end
        check("short_lf", long_flag_o, 0);
        // bounce rejection
        for (int b = 0; b < 4; b++) repeat (2) step(b % 2 == 0);
        repeat (10) begin
            step(0);
            check("bounce_lvl", key_level_o, 0);
        end
        check("bounce_cnt", press_count_o, 2);
        // long press
        step(0, 1);
        step(0);
        for (int i = 1; i <= 40; i++) begin
            step(1);
            if (i == 21) check("long_early", long_flag_o, 0);
            if (i == 22) check("long_set", long_flag_o, 1);
        end
        check("long_cnt", press_count_o, 3);
        repeat (10) step(0);
        check("long_sticky", long_flag_o, 1);
        // new press aligned with an ack rising edge
        step(0, 1);
        step(0);
        check("coll_pre", press_flag_o, 0);
        repeat (5) step(1);
        step(1, 1);
        check("coll_pf", press_flag_o, 1);
        check("coll_lf", long_flag_o, 0);
        check("coll_cnt", press_count_o, 4);
        repeat (10) step(0);
        // counter wrap
        repeat (2) step(0, 0, 1);
        for (int p = 0; p < 256; p++) begin
            repeat (8) step(1);
            check("wrap_cnt", press_count_o, (p + 1) % 256);
            repeat (8) step(0);
        end
        // randomized segments with occasional acks and resets
        repeat (80) begin
            bit pr;
            int n;
            pr = 1'($urandom_range(0, 1));
            n = $urandom_range(1, 24);
            repeat (n) step(pr, $urandom_range(0, 7) == 0, $urandom_range(0, 99) == 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
